// File: rtl/simon_host_bridge.sv
// Byte-stream host front end for the SIMON cipher controller: assembles key/block
// words from an inbound packet, runs the core handshake and streams the response back.
module simon_host_bridge #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic                clk,
    input  logic                nR,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                newData,
    output logic                newKey,
    output logic                enc_dec,
    output logic                readData,
    output logic [1:0][N-1:0]   blockIN,
    output logic [M-1:0][N-1:0] KEY,
    output logic [7:0]          infoIN,
    output logic [7:0]          countIN,
    input  logic                loadData,
    input  logic                doneKey,
    input  logic                doneData,
    input  logic [1:0][N-1:0]   outData,
    input  logic [7:0]          infoOUT,
    input  logic [7:0]          countOUT,
    output logic                busy
);

    localparam int KB   = M * N / 8;
    localparam int DB   = 2 * N / 8;
    localparam int TXB  = 2 + DB;
    localparam int MAXB = (KB > TXB) ? KB : TXB;
    localparam int CW   = $clog2(MAXB + 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] KB_LAST  = CW'(KB - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DB - 1);
    localparam logic [CW-1:0] TX_LAST  = CW'(TXB - 1);

    typedef enum logic [3:0] {
        S_HDR   = 4'd0,
        S_CNT   = 4'd1,
        S_KEY   = 4'd2,
        S_DATA  = 4'd3,
        S_ISSUE = 4'd4,
        S_WAIT  = 4'd5,
        S_ACK   = 4'd6,
        S_ERR   = 4'd7,
        S_SEND  = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          info_q, info_d;
    logic [7:0]          count_q, count_d;
    logic [M*N-1:0]      key_q, key_d;
    logic [2*N-1:0]      blk_q, blk_d;
    logic [TXB*8-1:0]    txbuf_q, txbuf_d;

    logic                rx_ready_q, rx_ready_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                new_data_q, new_data_d;
    logic                new_key_q, new_key_d;
    logic                enc_dec_q, enc_dec_d;
    logic                read_data_q, read_data_d;
    logic                busy_q, busy_d;

    logic                rx_fire_s;
    logic                tx_fire_s;
    logic [CW+2:0]       bidx_s;

    function automatic logic [7:0] pick_byte(input logic [TXB*8-1:0] vec,
                                             input logic [CW-1:0]    idx);
        logic [CW+2:0] bit_idx;
        bit_idx = {idx, 3'b000};
        return vec[bit_idx +: 8];
    endfunction

    assign rx_fire_s = rx_valid && rx_ready_q;
    assign tx_fire_s = tx_valid_q && tx_ready;
    assign bidx_s    = {cnt_q, 3'b000};

    // Next-state, packet assembly and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        info_d  = info_q;
        count_d = count_q;
        key_d   = key_q;
        blk_d   = blk_q;
        txbuf_d = txbuf_q;

        case (state_q)
            S_HDR: begin
                if (rx_fire_s) begin
                    info_d  = rx_data;
                    cnt_d   = CNT_ZERO;
                    state_d = S_CNT;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_CNT: begin
                if (rx_fire_s) begin
                    count_d = rx_data;
                    cnt_d   = CNT_ZERO;
                    state_d = info_q[1] ? S_KEY : S_DATA;
                end else begin
                    state_d = S_CNT;
                end
            end
            S_KEY: begin
                if (rx_fire_s) begin
                    key_d[bidx_s +: 8] = rx_data;
                    if (cnt_q == KB_LAST) begin
                        cnt_d   = CNT_ZERO;
                        state_d = S_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_KEY;
                end
            end
            S_DATA: begin
                if (rx_fire_s) begin
                    blk_d[bidx_s +: 8] = rx_data;
                    if (cnt_q == DB_LAST) begin
                        cnt_d   = CNT_ZERO;
                        // Without a key in this packet the core must already hold one.
                        state_d = (!info_q[1] && !doneKey) ? S_ERR : S_ISSUE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_ISSUE: begin
                if (loadData) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (doneData) begin
                    txbuf_d = {outData, countOUT, infoOUT};
                    cnt_d   = CNT_ZERO;
                    state_d = S_ACK;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ACK: begin
                if (!doneData) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_SEND;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_ERR: begin
                txbuf_d = {{(DB * 8){1'b0}}, count_q, info_q | 8'h80};
                cnt_d   = CNT_ZERO;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (tx_fire_s) begin
                    if (cnt_q == TX_LAST) begin
                        cnt_d   = CNT_ZERO;
                        state_d = S_HDR;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = S_HDR;
            end
        endcase

        rx_ready_d  = (state_d == S_HDR) || (state_d == S_CNT) ||
                      (state_d == S_KEY) || (state_d == S_DATA);
        tx_valid_d  = (state_d == S_SEND);
        tx_data_d   = tx_valid_d ? pick_byte(txbuf_d, cnt_d) : 8'h00;
        new_data_d  = (state_d == S_ISSUE);
        new_key_d   = (state_d == S_ISSUE) && info_d[1];
        enc_dec_d   = (state_d == S_ISSUE) ? info_d[0] : enc_dec_q;
        read_data_d = (state_d == S_ACK);
        busy_d      = (state_d != S_HDR);
    end

    // State, packet registers and output registers; nR clears everything mid-packet.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q     <= S_HDR;
            cnt_q       <= CNT_ZERO;
            info_q      <= 8'h00;
            count_q     <= 8'h00;
            key_q       <= '0;
            blk_q       <= '0;
            txbuf_q     <= '0;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            new_data_q  <= 1'b0;
            new_key_q   <= 1'b0;
            enc_dec_q   <= 1'b0;
            read_data_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            info_q      <= info_d;
            count_q     <= count_d;
            key_q       <= key_d;
            blk_q       <= blk_d;
            txbuf_q     <= txbuf_d;
            rx_ready_q  <= rx_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            new_data_q  <= new_data_d;
            new_key_q   <= new_key_d;
            enc_dec_q   <= enc_dec_d;
            read_data_q <= read_data_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign newData  = new_data_q;
    assign newKey   = new_key_q;
    assign enc_dec  = enc_dec_q;
    assign readData = read_data_q;
    assign busy     = busy_q;
    assign blockIN  = blk_q;
    assign KEY      = key_q;
    assign infoIN   = info_q;
    assign countIN  = count_q;

endmodule
